data_unpacker: RTL and testbench
================================

Name: data_unpacker

Overview:
- Width down-converter: accepts one wide word and emits it as NUM_SPLIT narrow slices, least-significant slice first.
- Sits upstream of the packer stage, between the wide memory read path and the narrow PE/operand stream.
- Slice ordering is the inverse of the packer, so a packer fed by this block reproduces the original wide word bit-exactly.
- Valid/ready handshake on both sides; one-word holding register; no bubble between consecutive wide words.

Parameters:
- IN_WIDTH, 128, wide input word width; must be an exact multiple of OUT_WIDTH (elaboration error otherwise).
- OUT_WIDTH, 64, narrow output slice width.
- OP_WIDTH, 16, operand width; informational only; OUT_WIDTH must be a multiple of it.
- Derived NUM_SPLIT = IN_WIDTH/OUT_WIDTH.
- Derived CNT_W = C_LOG_2(NUM_SPLIT)+1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_read_req  input  1  upstream word valid
- s_read_ready  output  1  block can accept a wide word this cycle
- s_read_data  input  IN_WIDTH  wide word
- m_read_req  output  1  slice valid
- m_read_ready  input  1  downstream accepts slice
- m_read_data  output  OUT_WIDTH  current slice
- m_read_last  output  1  current slice is the final slice of its word
- slice_idx  output  CNT_W  index of current slice (0..NUM_SPLIT-1)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Handshake: a transfer occurs on a side when req && ready are high at the same posedge. req must not depend combinationally on ready on either side.
- State:
  - data: IN_WIDTH shift register.
  - valid: 1 bit.
  - cnt: CNT_W bits.
- Reset values: data=0, valid=0, cnt=0. Therefore m_read_req=0, m_read_data=0, m_read_last=0 (NUM_SPLIT>1), slice_idx=0, s_read_ready=1 in the cycle after reset.
- Reset mid-word discards the remaining slices.
- Outputs:
  - m_read_req = valid.
  - m_read_data = data[OUT_WIDTH-1:0].
  - slice_idx = cnt.
  - m_read_last = valid && (cnt == NUM_SPLIT-1).
- Input ready is combinational: s_read_ready = !valid || (m_read_last && m_read_ready).
- Load (input transfer): data <= s_read_data, cnt <= 0, valid <= 1.
  - Latency: slice 0 is visible the cycle after the input transfer.
- Slice consume (output transfer, not last): data <= data >> OUT_WIDTH (zero fill), cnt <= cnt+1.
- Last-slice consume with no simultaneous input transfer: valid <= 0, cnt <= 0, data unchanged.
- Simultaneous last-slice consume and input transfer: load wins.
  - The new word's slice 0 appears the next cycle.
  - Sustained throughput is 1 slice/cycle with no bubble between words.
- Downstream stall (m_read_ready=0): data, cnt and valid hold, and m_read_data is stable.
- Input while busy: s_read_req while valid and not on the last-slice handoff is not accepted (ready=0). Upstream holds its word.
- NUM_SPLIT==1: same logic with cnt fixed at 0 and m_read_last = valid. Behaves as a one-entry pipeline register with full throughput.
- Upper bound: cnt never exceeds NUM_SPLIT-1. The bench asserts this.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset 3 cycles, release, keep s_read_req=0.
  - Response: m_read_req=0, m_read_data=0, s_read_ready=1 on every cycle.
- Single word, default parameters:
  - Stimulus: s_read_data=128'h1111_2222_3333_4444_5555_6666_7777_8888, m_read_ready=1 throughout.
  - Response: cycle+1 data=64'h5555_6666_7777_8888, idx=0, last=0. Cycle+2 data=64'h1111_2222_3333_4444, idx=1, last=1. Cycle+3 m_read_req=0.
- Back-to-back words:
  - Stimulus: s_read_req held high with words A then B, m_read_ready=1.
  - Response: s_read_ready pulses on A's last slice. Output sequence is A0,A1,B0,B1 on 4 consecutive cycles with no gap.
- Downstream stall:
  - Stimulus: load word A, drop m_read_ready for 5 cycles during slice 0.
  - Response: A0 held stable with idx=0 and s_read_ready=0. Resume gives A1, then last.
- Reset mid-word:
  - Stimulus: assert reset while slice 0 of word A is pending.
  - Response: next cycle m_read_req=0 and idx=0. A following word C emits C0 first, with no trace of A.
- Round trip:
  - Stimulus: chain this block into the packer, both at IN/OUT 128/64, with 100 random words.
  - Response: packer output equals the input sequence in order. Repeat the chain with IN_WIDTH=OUT_WIDTH=64 and confirm passthrough at one word per cycle.

Source files
------------

// File: rtl/data_unpacker.sv
// data_unpacker: wide-to-narrow width converter.
// Accepts one IN_WIDTH word and emits it as NUM_SPLIT OUT_WIDTH slices, least-significant
// slice first. A single holding register keeps the word, and a new word can load on the
// same edge that the final slice leaves, so a back-to-back stream has no bubble.
module data_unpacker #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int OP_WIDTH  = 16,
    localparam int NUM_SPLIT = IN_WIDTH / OUT_WIDTH,
    localparam int CNT_W     = $clog2(NUM_SPLIT) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    // wide upstream side
    input  logic                 s_read_req,
    output logic                 s_read_ready,
    input  logic [IN_WIDTH-1:0]  s_read_data,
    // narrow downstream side
    output logic                 m_read_req,
    input  logic                 m_read_ready,
    output logic [OUT_WIDTH-1:0] m_read_data,
    output logic                 m_read_last,
    output logic [CNT_W-1:0]     slice_idx
);

    // Parameter legality: slices must tile the word, operands must tile a slice.
    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_in_width
            $error("data_unpacker: IN_WIDTH must be an exact multiple of OUT_WIDTH");
        end
        if ((OUT_WIDTH % OP_WIDTH) != 0) begin : g_bad_op_width
            $error("data_unpacker: OUT_WIDTH must be a multiple of OP_WIDTH");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SPLIT - 1);

    // Holding register (shifted down as slices leave), valid flag and slice counter.
    logic [IN_WIDTH-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;
    logic is_last;

    // Output view of the state; the current slice is always the low bits of the register.
    always_comb begin
        is_last      = valid_q && (cnt_q == LAST_IDX);
        m_read_req   = valid_q;
        m_read_data  = data_q[OUT_WIDTH-1:0];
        m_read_last  = is_last;
        slice_idx    = cnt_q;
        // Ready when empty, or when the final slice is leaving this very cycle.
        s_read_ready = !valid_q || (is_last && m_read_ready);
        in_fire      = s_read_req && s_read_ready;
        out_fire     = valid_q && m_read_ready;
    end

    // Next-state: a load takes priority over the last-slice drain so words chain with no gap.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (in_fire) begin
            data_d  = s_read_data;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (out_fire) begin
            if (is_last) begin
                // Word fully consumed; leave data alone, it is no longer visible as valid.
                valid_d = 1'b0;
                cnt_d   = '0;
            end else begin
                data_d = data_q >> OUT_WIDTH;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any partially emitted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker: default 128/64 instance plus a 64/64 passthrough instance.
module tb_data_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 128 -> 64 instance
    logic         s_req, s_ready, m_req, m_ready, m_last;
    logic [127:0] s_data;
    logic [63:0]  m_data;
    logic [1:0]   idx;

    // 64 -> 64 passthrough instance
    logic         pt_s_req, pt_s_ready, pt_m_req, pt_m_ready, pt_m_last;
    logic [63:0]  pt_s_data, pt_m_data;
    logic [0:0]   pt_idx;

    int checks = 0;
    int errors = 0;

    data_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(64), .OP_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .s_read_req(s_req), .s_read_ready(s_ready), .s_read_data(s_data),
        .m_read_req(m_req), .m_read_ready(m_ready), .m_read_data(m_data),
        .m_read_last(m_last), .slice_idx(idx)
    );

    data_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(64), .OP_WIDTH(16)) u_pt (
        .clk(clk), .reset(reset),
        .s_read_req(pt_s_req), .s_read_ready(pt_s_ready), .s_read_data(pt_s_data),
        .m_read_req(pt_m_req), .m_read_ready(pt_m_ready), .m_read_data(pt_m_data),
        .m_read_last(pt_m_last), .slice_idx(pt_idx)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slice index must stay within 0..NUM_SPLIT-1 whenever out of reset.
    always @(negedge clk) begin
        if (reset === 1'b0) check_eq("idx_bound", 128'(idx <= 2'd1), 128'd1);
    end

    localparam logic [127:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] WA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] WB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] WC = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;

    logic [127:0] rt_words [100];
    logic [63:0]  pt_words [10];

    initial begin
        int widx;
        int ridx;
        int budget;
        logic [63:0] lo;

        reset = 1'b1; s_req = 1'b0; s_data = '0; m_ready = 1'b1;
        pt_s_req = 1'b0; pt_s_data = '0; pt_m_ready = 1'b1;

        // Reset then idle
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_req", 128'(m_req), 128'd0);
            check_eq("idle_data", 128'(m_data), 128'd0);
            check_eq("idle_s_ready", 128'(s_ready), 128'd1);
            check_eq("idle_idx", 128'(idx), 128'd0);
            check_eq("idle_last", 128'(m_last), 128'd0);
        end
        $display("phase reset/idle done");

        // Single word
        s_req = 1'b1; s_data = W1;
        tick();
        s_req = 1'b0;
        check_eq("w1_s0_data", 128'(m_data), 128'h5555_6666_7777_8888);
        check_eq("w1_s0_idx", 128'(idx), 128'd0);
        check_eq("w1_s0_last", 128'(m_last), 128'd0);
        check_eq("w1_s0_req", 128'(m_req), 128'd1);
        check_eq("w1_s0_s_ready", 128'(s_ready), 128'd0);
        tick();
        check_eq("w1_s1_data", 128'(m_data), 128'h1111_2222_3333_4444);
        check_eq("w1_s1_idx", 128'(idx), 128'd1);
        check_eq("w1_s1_last", 128'(m_last), 128'd1);
        tick();
        check_eq("w1_done_req", 128'(m_req), 128'd0);
        check_eq("w1_done_s_ready", 128'(s_ready), 128'd1);
        $display("phase single word done");

        // Back-to-back A then B, upstream valid held high
        s_req = 1'b1; s_data = WA;
        tick();
        s_data = WB;
        check_eq("bb_a0", 128'(m_data), WA[63:0]);
        check_eq("bb_a0_s_ready", 128'(s_ready), 128'd0);
        tick();
        check_eq("bb_a1", 128'(m_data), WA[127:64]);
        check_eq("bb_a1_last", 128'(m_last), 128'd1);
        check_eq("bb_a1_s_ready", 128'(s_ready), 128'd1);
        tick();
        s_req = 1'b0;
        check_eq("bb_b0", 128'(m_data), WB[63:0]);
        check_eq("bb_b0_req", 128'(m_req), 128'd1);
        check_eq("bb_b0_idx", 128'(idx), 128'd0);
        tick();
        check_eq("bb_b1", 128'(m_data), WB[127:64]);
        check_eq("bb_b1_last", 128'(m_last), 128'd1);
        tick();
        check_eq("bb_done_req", 128'(m_req), 128'd0);
        $display("phase back-to-back done");

        // Downstream stall during slice 0
        s_req = 1'b1; s_data = WA; m_ready = 1'b0;
        tick();
        s_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_data", 128'(m_data), WA[63:0]);
            check_eq("stall_idx", 128'(idx), 128'd0);
            check_eq("stall_req", 128'(m_req), 128'd1);
            check_eq("stall_s_ready", 128'(s_ready), 128'd0);
            tick();
        end
        m_ready = 1'b1;
        check_eq("stall_hold_a0", 128'(m_data), WA[63:0]);
        tick();
        check_eq("stall_a1", 128'(m_data), WA[127:64]);
        check_eq("stall_a1_last", 128'(m_last), 128'd1);
        tick();
        check_eq("stall_done_req", 128'(m_req), 128'd0);
        $display("phase stall done");

        // Reset while slice 0 pending
        s_req = 1'b1; s_data = WA; m_ready = 1'b0;
        tick();
        s_req = 1'b0;
        check_eq("rst_a0_pending", 128'(m_data), WA[63:0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_req", 128'(m_req), 128'd0);
        check_eq("rst_idx", 128'(idx), 128'd0);
        check_eq("rst_data", 128'(m_data), 128'd0);
        m_ready = 1'b1; s_req = 1'b1; s_data = WC;
        tick();
        s_req = 1'b0;
        check_eq("rst_c0", 128'(m_data), WC[63:0]);
        check_eq("rst_c0_idx", 128'(idx), 128'd0);
        tick();
        check_eq("rst_c1", 128'(m_data), WC[127:64]);
        check_eq("rst_c1_last", 128'(m_last), 128'd1);
        tick();
        $display("phase reset mid-word done");

        // Round trip: reassemble slices in order, random downstream back-pressure
        for (int i = 0; i < 100; i++)
            rt_words[i] = {$urandom, $urandom, $urandom, $urandom};
        widx = 0; ridx = 0; budget = 0; lo = '0;
        while (ridx < 100 && budget < 2000) begin
            s_req   = (widx < 100);
            s_data  = rt_words[(widx < 100) ? widx : 99];
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_req && m_ready) begin
                if (idx == 2'd0) begin
                    lo = m_data;
                    check_eq("rt_first_not_last", 128'(m_last), 128'd0);
                end else begin
                    check_eq("rt_last", 128'(m_last), 128'd1);
                    check_eq("rt_word", {m_data, lo}, rt_words[ridx]);
                    $display("round trip word %0d reassembled", ridx);
                    ridx++;
                end
            end
            if (s_req && s_ready) widx++;
            tick();
            budget++;
        end
        check_eq("rt_count", 128'(ridx), 128'd100);
        s_req = 1'b0; m_ready = 1'b1;
        tick();

        // 64/64 passthrough: one word per cycle, each word visible one cycle later
        for (int i = 0; i < 10; i++)
            pt_words[i] = {$urandom, $urandom};
        for (int i = 0; i <= 10; i++) begin
            pt_s_req  = (i < 10);
            pt_s_data = pt_words[(i < 10) ? i : 9];
            #1;
            if (i < 10) check_eq("pt_s_ready", 128'(pt_s_ready), 128'd1);
            if (i > 0) begin
                check_eq("pt_req", 128'(pt_m_req), 128'd1);
                check_eq("pt_data", 128'(pt_m_data), 128'(pt_words[i-1]));
                check_eq("pt_last", 128'(pt_m_last), 128'd1);
                check_eq("pt_idx", 128'(pt_idx), 128'd0);
            end
            tick();
        end
        pt_s_req = 1'b0;
        tick();
        check_eq("pt_done_req", 128'(pt_m_req), 128'd0);
        $display("phase passthrough done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
